// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Shares the instruction memory's single address port between CPU fetch and a
// byte-serial program-load stream. During a load, incoming bytes are packed
// little-endian into 32-bit words that are written to byte addresses
// 0, 4, 8, ... while the CPU is held in stall. Once the last word is written,
// one DONE cycle follows and the port is handed back to the PC.
//
// Ports:
//   i_clk          system clock, all state changes on the rising edge
//   i_reset        synchronous, active-high reset
//   i_start        one-cycle load request, honoured only in IDLE
//   i_load_len     number of words to load, sampled together with i_start
//   i_byte_valid   host byte valid
//   i_byte_data    host byte
//   o_byte_ready   loader accepts a byte this cycle
//   i_cpu_pc       fetch address from the PC
//   o_mem_addr     address to the instruction memory (PC or loader address)
//   o_mem_we       instruction memory write enable (WRITE state only)
//   o_mem_wdata    assembled word for the instruction memory
//   o_cpu_stall    holds PC / register updates while a load is in progress
//   o_done         one-cycle pulse when a load completes
//   o_error        sticky: the last start carried an illegal length
// -----------------------------------------------------------------------------
module imem_program_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_load_len,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  input  logic [ADDR_WIDTH-1:0] i_cpu_pc,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_cpu_stall,
  output logic                  o_done,
  output logic                  o_error
);

  // Word counter only needs to reach MAX_WORDS-1; keep at least one bit.
  localparam int          WCW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [31:0] MAX_W_U   = MAX_WORDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WCW-1:0]        r_word_cnt;
  logic [WCW-1:0]        r_last_idx;   // load_len-1, captured at start
  logic [1:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_asm;
  logic                  r_error;

  logic                  w_len_zero;
  logic                  w_len_legal;
  logic                  w_last_word;
  logic [ADDR_WIDTH-1:0] w_loader_addr;

  assign w_len_zero    = (i_load_len == '0);
  assign w_len_legal   = !w_len_zero && (32'(i_load_len) <= MAX_W_U);
  assign w_last_word   = (r_word_cnt == r_last_idx);
  // Byte address of the current word: word_cnt * 4, widened to the port.
  assign w_loader_addr = ADDR_WIDTH'({r_word_cnt, 2'b00});

  assign o_mem_wdata   = r_asm;
  assign o_error       = r_error;

  // Next-state and port-arbitration decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next       = r_state;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_cpu_stall  = 1'b1;
    o_done       = 1'b0;
    o_mem_addr   = w_loader_addr;

    case (r_state)
      S_IDLE: begin
        o_cpu_stall = 1'b0;
        o_mem_addr  = i_cpu_pc;
        if (i_start) begin
          if (w_len_zero)       w_next = S_DONE;
          else if (w_len_legal) w_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        o_byte_ready = 1'b1;
        if (i_byte_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_mem_we = 1'b1;
        w_next   = w_last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        o_done     = 1'b1;
        o_mem_addr = i_cpu_pc;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counters, assembly register and sticky error.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_last_idx <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_zero) begin
              r_error <= 1'b0;
            end else if (w_len_legal) begin
              r_error    <= 1'b0;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
              r_asm      <= '0;
              r_last_idx <= WCW'(i_load_len - 1'b1);
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // Byte n of a word lands in bits [8n+7:8n] (little-endian).
          if (i_byte_valid) begin
            r_asm[{r_byte_cnt, 3'b000} +: 8] <= i_byte_data;
            r_byte_cnt                       <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (!w_last_word) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            r_byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// Testbench for imem_program_loader: a table of per-cycle vectors for the
// single-word load, zero/illegal lengths and start-during-DONE, followed by
// hand-written sequences for gapped multi-word loads, start/byte during busy
// states, and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_load_len;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic [31:0] i_cpu_pc;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic        o_cpu_stall;
  logic        o_done;
  logic        o_error;

  imem_program_loader dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_load_len   (i_load_len),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .i_cpu_pc     (i_cpu_pc),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_stall  (o_cpu_stall),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write / done monitor, sampled mid-cycle.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  int          stall_low = 0;

  always @(negedge clk) begin
    if (o_mem_we) begin
      wr_addr.push_back(o_mem_addr);
      wr_data.push_back(o_mem_wdata);
    end
    if (o_done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [7:0]  len;
    logic        bv;
    logic [7:0]  bd;
    logic [31:0] pc;
    logic        e_rdy;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_wdchk;
    logic [31:0] e_wd;
    logic        e_stall;
    logic        e_done;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic st, input logic [7:0] len, input logic bv,
                              input logic [7:0] bd, input logic [31:0] pc,
                              input logic rdy, input logic we, input logic [31:0] addr,
                              input logic wdchk, input logic [31:0] wd,
                              input logic stall, input logic dn, input logic err);
    vec_t v;
    v.st = st; v.len = len; v.bv = bv; v.bd = bd; v.pc = pc;
    v.e_rdy = rdy; v.e_we = we; v.e_addr = addr; v.e_wdchk = wdchk; v.e_wd = wd;
    v.e_stall = stall; v.e_done = dn; v.e_err = err;
    return v;
  endfunction

  // Present a byte until accepted; waits = cycles spent, including the accept.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    logic acc;
    acc          = 1'b0;
    waits        = 0;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    while (!acc && waits < 20) begin
      acc = o_byte_ready;
      if (!o_cpu_stall) stall_low++;
      tick();
      waits++;
    end
    i_byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
    repeat (gap) begin
      if (!o_cpu_stall) stall_low++;
      tick();
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!o_done && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(o_done), 64'd1);
    tick();
  endtask

  task automatic pulse_start(input logic [7:0] len);
    i_start    = 1'b1;
    i_load_len = len;
    tick();
    i_start    = 1'b0;
    i_load_len = 8'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d0;

    i_reset = 1'b1; i_start = 1'b0; i_load_len = 8'd0;
    i_byte_valid = 1'b0; i_byte_data = 8'd0; i_cpu_pc = 32'h0000_0ABC;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    check("rst_ready", 64'(o_byte_ready), 64'd0);
    check("rst_we",    64'(o_mem_we),     64'd0);
    check("rst_wdata", 64'(o_mem_wdata),  64'd0);
    check("rst_stall", 64'(o_cpu_stall),  64'd0);
    check("rst_done",  64'(o_done),       64'd0);
    check("rst_error", 64'(o_error),      64'd0);
    check("rst_addr",  64'(o_mem_addr),   64'h0ABC);

    //               st len   bv bd     pc           rdy we addr          chk wd             stl dn err
    // single-word load, bytes 02 10 81 E2
    vecs[0]  = mk(1, 8'd1,  0, 8'h00, 32'h100,  0, 0, 32'h100, 1, 32'h0,        0, 0, 0);
    vecs[1]  = mk(0, 8'd0,  1, 8'h02, 32'h104,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[2]  = mk(0, 8'd0,  1, 8'h10, 32'h104,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[3]  = mk(0, 8'd0,  1, 8'h81, 32'h104,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[4]  = mk(0, 8'd0,  1, 8'hE2, 32'h104,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[5]  = mk(0, 8'd0,  0, 8'h00, 32'h108,  0, 1, 32'h0,   1, 32'hE2811002, 1, 0, 0);
    vecs[6]  = mk(0, 8'd0,  0, 8'h00, 32'h200,  0, 0, 32'h200, 0, 32'h0,        1, 1, 0);
    vecs[7]  = mk(0, 8'd0,  0, 8'h00, 32'h204,  0, 0, 32'h204, 0, 32'h0,        0, 0, 0);
    // zero length: straight to DONE, no write
    vecs[8]  = mk(1, 8'd0,  0, 8'h00, 32'h300,  0, 0, 32'h300, 0, 32'h0,        0, 0, 0);
    vecs[9]  = mk(0, 8'd0,  0, 8'h00, 32'h304,  0, 0, 32'h304, 0, 32'h0,        1, 1, 0);
    vecs[10] = mk(0, 8'd0,  0, 8'h00, 32'h308,  0, 0, 32'h308, 0, 32'h0,        0, 0, 0);
    // illegal length 33: error, stay IDLE; next legal start clears error
    vecs[11] = mk(1, 8'd33, 0, 8'h00, 32'h30C,  0, 0, 32'h30C, 0, 32'h0,        0, 0, 0);
    vecs[12] = mk(0, 8'd0,  0, 8'h00, 32'h310,  0, 0, 32'h310, 0, 32'h0,        0, 0, 1);
    vecs[13] = mk(1, 8'd1,  0, 8'h00, 32'h314,  0, 0, 32'h314, 0, 32'h0,        0, 0, 1);
    vecs[14] = mk(0, 8'd0,  0, 8'h00, 32'h318,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[15] = mk(0, 8'd0,  1, 8'h11, 32'h318,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[16] = mk(0, 8'd0,  1, 8'h22, 32'h318,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[17] = mk(0, 8'd0,  1, 8'h33, 32'h318,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[18] = mk(0, 8'd0,  1, 8'h44, 32'h318,  1, 0, 32'h0,   0, 32'h0,        1, 0, 0);
    vecs[19] = mk(0, 8'd0,  0, 8'h00, 32'h400,  0, 1, 32'h0,   1, 32'h44332211, 1, 0, 0);
    // start and a byte offered during DONE are both ignored
    vecs[20] = mk(1, 8'd1,  1, 8'hFF, 32'h404,  0, 0, 32'h404, 0, 32'h0,        1, 1, 0);
    vecs[21] = mk(0, 8'd0,  1, 8'hFF, 32'h408,  0, 0, 32'h408, 0, 32'h0,        0, 0, 0);
    vecs[22] = mk(0, 8'd0,  0, 8'h00, 32'h40C,  0, 0, 32'h40C, 0, 32'h0,        0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      i_start      = vecs[i].st;
      i_load_len   = vecs[i].len;
      i_byte_valid = vecs[i].bv;
      i_byte_data  = vecs[i].bd;
      i_cpu_pc     = vecs[i].pc;
      #1;
      check($sformatf("v%0d_ready", i), 64'(o_byte_ready), 64'(vecs[i].e_rdy));
      check($sformatf("v%0d_we",    i), 64'(o_mem_we),     64'(vecs[i].e_we));
      check($sformatf("v%0d_addr",  i), 64'(o_mem_addr),   64'(vecs[i].e_addr));
      if (vecs[i].e_wdchk)
        check($sformatf("v%0d_wdata", i), 64'(o_mem_wdata), 64'(vecs[i].e_wd));
      check($sformatf("v%0d_stall", i), 64'(o_cpu_stall),  64'(vecs[i].e_stall));
      check($sformatf("v%0d_done",  i), 64'(o_done),       64'(vecs[i].e_done));
      check($sformatf("v%0d_error", i), 64'(o_error),      64'(vecs[i].e_err));
      tick();
    end
    i_start = 1'b0; i_byte_valid = 1'b0;

    // Three words, byte_valid every other cycle
    wr_addr.delete(); wr_data.delete(); stall_low = 0;
    pulse_start(8'd3);
    for (int i = 0; i < 12; i++) send_byte(8'hA0 + 8'(i), 1, w);
    wait_done("gap_done");
    check("gap_stall_low", 64'(stall_low), 64'd0);
    check("gap_nwrites", 64'(wr_addr.size()), 64'd3);
    if (wr_addr.size() == 3) begin
      check("gap_a0", 64'(wr_addr[0]), 64'h0);
      check("gap_d0", 64'(wr_data[0]), 64'hA3A2A1A0);
      check("gap_a1", 64'(wr_addr[1]), 64'h4);
      check("gap_d1", 64'(wr_data[1]), 64'hA7A6A5A4);
      check("gap_a2", 64'(wr_addr[2]), 64'h8);
      check("gap_d2", 64'(wr_data[2]), 64'hABAAA9A8);
    end
    check("gap_release", 64'(o_cpu_stall), 64'd0);

    // Start during COLLECT ignored; byte offered during WRITE waits a cycle
    wr_addr.delete(); wr_data.delete();
    pulse_start(8'd2);
    send_byte(8'hC0, 0, w);
    pulse_start(8'd5);
    send_byte(8'hC1, 0, w);
    send_byte(8'hC2, 0, w);
    send_byte(8'hC3, 0, w);
    check("busy_write_ready", 64'(o_byte_ready), 64'd0);
    send_byte(8'hC4, 0, w);
    check("busy_byte_held", 64'(w), 64'd2);
    send_byte(8'hC5, 0, w);
    send_byte(8'hC6, 0, w);
    send_byte(8'hC7, 0, w);
    wait_done("busy_done");
    check("busy_nwrites", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("busy_a0", 64'(wr_addr[0]), 64'h0);
      check("busy_d0", 64'(wr_data[0]), 64'hC3C2C1C0);
      check("busy_a1", 64'(wr_addr[1]), 64'h4);
      check("busy_d1", 64'(wr_data[1]), 64'hC7C6C5C4);
    end

    // Reset after 2 bytes of word 1 in a 3-word load
    wr_addr.delete(); wr_data.delete();
    d0 = done_cnt;
    i_cpu_pc = 32'h0000_0ABC;
    pulse_start(8'd3);
    for (int i = 0; i < 6; i++) send_byte(8'hD0 + 8'(i), 0, w);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_rst_ready", 64'(o_byte_ready), 64'd0);
    check("mid_rst_we",    64'(o_mem_we),     64'd0);
    check("mid_rst_wdata", 64'(o_mem_wdata),  64'd0);
    check("mid_rst_stall", 64'(o_cpu_stall),  64'd0);
    check("mid_rst_done",  64'(o_done),       64'd0);
    check("mid_rst_error", 64'(o_error),      64'd0);
    check("mid_rst_addr",  64'(o_mem_addr),   64'h0ABC);
    check("mid_rst_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      check("mid_rst_a0", 64'(wr_addr[0]), 64'h0);
      check("mid_rst_d0", 64'(wr_data[0]), 64'hD3D2D1D0);
    end
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset clears a sticky error
    pulse_start(8'd200);
    check("err_set", 64'(o_error), 64'd1);
    check("err_no_stall", 64'(o_cpu_stall), 64'd0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("err_rst_clear", 64'(o_error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
